// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file, control decoder and load-use hazard detector.
// Build option: define ID_REGFILE_BYPASS_EN for same-cycle write-back to read bypass.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        branch_taken,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        pc_write_en,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src_imm,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src_imm;
  logic        dec_branch, dec_jump, dec_illegal;
  logic        uses_rs1, uses_rs2;
  logic        load_use_stall;
  logic [31:0] rf_rs1, rf_rs2;

  assign opcode   = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign funct3   = instr_q[14:12];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign funct7b5 = instr_q[30];
  assign id_pc    = pc_q;

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  always_comb begin
    dec_reg_write   = 1'b0;
    dec_mem_read    = 1'b0;
    dec_mem_write   = 1'b0;
    dec_alu_src_imm = 1'b0;
    dec_branch      = 1'b0;
    dec_jump        = 1'b0;
    dec_illegal     = 1'b0;
    uses_rs1        = 1'b0;
    uses_rs2        = 1'b0;
    imm             = 32'h0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_reg_write = 1'b1;
        imm           = imm_u;
      end
      OPC_JAL: begin
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
        imm           = imm_j;
      end
      OPC_JALR: begin
        dec_reg_write   = 1'b1;
        dec_jump        = 1'b1;
        dec_alu_src_imm = 1'b1;
        uses_rs1        = 1'b1;
        imm             = imm_i;
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        imm        = imm_b;
      end
      OPC_LOAD: begin
        dec_reg_write   = 1'b1;
        dec_mem_read    = 1'b1;
        dec_alu_src_imm = 1'b1;
        uses_rs1        = 1'b1;
        imm             = imm_i;
      end
      OPC_STORE: begin
        dec_mem_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        imm             = imm_s;
      end
      OPC_OPIMM: begin
        dec_reg_write   = 1'b1;
        dec_alu_src_imm = 1'b1;
        uses_rs1        = 1'b1;
        imm             = imm_i;
      end
      OPC_OP: begin
        dec_reg_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // A load in EX whose result this instruction needs: hold IF/ID one cycle and send a bubble.
  assign load_use_stall = valid_q & ex_mem_read & (ex_rd != 5'd0) &
                          ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2)));
  assign pc_write_en    = ~load_use_stall;
  assign id_valid       = valid_q & ~load_use_stall;

  assign reg_write   = id_valid & dec_reg_write;
  assign mem_read    = id_valid & dec_mem_read;
  assign mem_write   = id_valid & dec_mem_write;
  assign alu_src_imm = id_valid & dec_alu_src_imm;
  assign branch      = id_valid & dec_branch;
  assign jump        = id_valid & dec_jump;
  assign illegal     = id_valid & dec_illegal;

  // Flush takes priority over the stall hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (branch_taken) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (!load_use_stall) begin
      instr_q <= instr_in;
      pc_q    <= pc_in;
      valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign rf_rs1 = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rf_rs2 = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

`ifdef ID_REGFILE_BYPASS_EN
  assign rs1_data = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_data : rf_rs1;
  assign rs2_data = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_data : rf_rs2;
`else
  assign rs1_data = rf_rs1;
  assign rs2_data = rf_rs2;
`endif

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: each cycle's expected ID outputs are queued with the stimulus and compared mid-cycle.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in, pc_in, wb_data;
  logic        branch_taken, ex_mem_read, wb_we;
  logic [4:0]  ex_rd, wb_rd;
  logic        pc_write_en, id_valid, funct7b5;
  logic [31:0] id_pc, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        reg_write, mem_read, mem_write, alu_src_imm, branch, jump, illegal;

  id_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
    .branch_taken(branch_taken), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_write_en(pc_write_en), .id_valid(id_valid), .id_pc(id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .funct3(funct3), .funct7b5(funct7b5),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src_imm(alu_src_imm), .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] RW = 7'b1000000, MR = 7'b0100000, MW = 7'b0010000,
                         AL = 7'b0001000, BR = 7'b0000100, IL = 7'b0000001;

  typedef struct packed {
    logic        valid;
    logic        pcwe;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  ctrl;
    logic        chk1;
    logic [31:0] d1;
    logic        chk2;
    logic [31:0] d2;
  } exp_t;

  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   row     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic pcwe, input logic [31:0] pc,
                              input logic [4:0] r, input logic [31:0] im, input logic [6:0] c,
                              input logic c1, input logic [31:0] d1, input logic c2, input logic [31:0] d2);
    exp_t e;
    e.valid = v; e.pcwe = pcwe; e.pc = pc; e.rd = r; e.imm = im; e.ctrl = c;
    e.chk1 = c1; e.d1 = d1; e.chk2 = c2; e.d2 = d2;
    return e;
  endfunction

  // One cycle: drive at negedge, queue the expected view of the instruction now in ID, compare before the next edge.
  task automatic step(input logic [31:0] ii, input logic [31:0] pi, input logic bt,
                      input logic mr, input logic [4:0] exrd,
                      input logic we, input logic [4:0] wrd, input logic [31:0] wd, input exp_t e);
    exp_t got;
    @(negedge clk);
    reset = 1'b0;
    instr_in = ii; pc_in = pi; branch_taken = bt;
    ex_mem_read = mr; ex_rd = exrd; wb_we = we; wb_rd = wrd; wb_data = wd;
    sb.push_back(e);
    #2;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk($sformatf("c%0d id_valid", row), {31'b0, id_valid}, {31'b0, got.valid});
      chk($sformatf("c%0d pc_write_en", row), {31'b0, pc_write_en}, {31'b0, got.pcwe});
      chk($sformatf("c%0d id_pc", row), id_pc, got.pc);
      chk($sformatf("c%0d rd", row), {27'b0, rd}, {27'b0, got.rd});
      chk($sformatf("c%0d imm", row), imm, got.imm);
      chk($sformatf("c%0d ctrl", row),
          {25'b0, reg_write, mem_read, mem_write, alu_src_imm, branch, jump, illegal},
          {25'b0, got.ctrl});
      if (got.chk1) chk($sformatf("c%0d rs1_data", row), rs1_data, got.d1);
      if (got.chk2) chk($sformatf("c%0d rs2_data", row), rs2_data, got.d2);
    end
    row++;
  endtask

  logic [31:0] bypass_exp;

  initial begin
    reset = 1'b1;
    instr_in = 32'h0; pc_in = 32'h0; branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
`ifdef ID_REGFILE_BYPASS_EN
    bypass_exp = 32'h1234_5678;
`else
    bypass_exp = 32'h0;
`endif
    #3;
    chk("reset id_valid", {31'b0, id_valid}, 32'd0);
    chk("reset pc_write_en", {31'b0, pc_write_en}, 32'd1);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset ctrl", {25'b0, reg_write, mem_read, mem_write, alu_src_imm, branch, jump, illegal}, 32'd0);
    @(posedge clk);

    // NOP bubble after reset; fetch addi x1,x0,5; attempt write to x0.
    step(32'h0050_0093, 32'd4, 0, 0, 5'd0, 1, 5'd0, 32'hDEAD_BEEF,
         mk(0, 1, 32'h0, 5'd0, 32'h0, 7'b0, 0, 0, 0, 0));
    // addi x1,x0,5 in ID; write x5.
    step(32'h0070_0113, 32'd8, 0, 0, 5'd0, 1, 5'd5, 32'h55,
         mk(1, 1, 32'd4, 5'd1, 32'd5, RW | AL, 1, 32'h0, 0, 0));
    // addi x2,x0,7 in ID: x0 must read zero after the ignored write; write x7.
    step(32'h0072_8333, 32'd12, 0, 0, 5'd0, 1, 5'd7, 32'h77,
         mk(1, 1, 32'd8, 5'd2, 32'd7, RW | AL, 1, 32'h0, 0, 0));
    // add x6,x5,x7 with a load to x5 in EX: bubble, fetch stalled.
    step(32'hFE00_0EE3, 32'd16, 0, 1, 5'd5, 0, 5'd0, 32'h0,
         mk(0, 0, 32'd12, 5'd6, 32'h0, 7'b0, 1, 32'h55, 1, 32'h77));
    // Same add released.
    step(32'hFE00_0EE3, 32'd16, 0, 0, 5'd0, 0, 5'd0, 32'h0,
         mk(1, 1, 32'd12, 5'd6, 32'h0, RW, 1, 32'h55, 1, 32'h77));
    // beq x0,x0,-4.
    step(32'hFFFF_FFFF, 32'd20, 0, 0, 5'd0, 0, 5'd0, 32'h0,
         mk(1, 1, 32'd16, 5'd29, 32'hFFFF_FFFC, BR, 1, 32'h0, 1, 32'h0));
    // All-ones word is illegal.
    step(32'h0072_8333, 32'd24, 0, 0, 5'd0, 0, 5'd0, 32'h0,
         mk(1, 1, 32'd20, 5'd31, 32'h0, IL, 0, 0, 0, 0));
    // Stall and flush together: bubble now, NOP/pc 0 next.
    step(32'h0050_0093, 32'd28, 1, 1, 5'd5, 0, 5'd0, 32'h0,
         mk(0, 0, 32'd24, 5'd6, 32'h0, 7'b0, 0, 0, 0, 0));
    step(32'h0030_A423, 32'd32, 0, 0, 5'd0, 0, 5'd0, 32'h0,
         mk(0, 1, 32'h0, 5'd0, 32'h0, 7'b0, 0, 0, 0, 0));
    // sw x3,8(x1) reads x3 while WB writes it.
    step(32'h1234_54B7, 32'd36, 0, 0, 5'd0, 1, 5'd3, 32'h1234_5678,
         mk(1, 1, 32'd32, 5'd8, 32'd8, MW | AL, 1, 32'h0, 1, bypass_exp));
    // lui x9,0x12345 (rs2 field = x3, now committed).
    step(32'h0041_2283, 32'd40, 0, 0, 5'd0, 0, 5'd0, 32'h0,
         mk(1, 1, 32'd36, 5'd9, 32'h1234_5000, RW, 0, 0, 1, 32'h1234_5678));
    // lw x5,4(x2): load in EX targets the unused rs2 field, so no stall.
    step(32'h0000_0013, 32'd44, 0, 1, 5'd4, 0, 5'd0, 32'h0,
         mk(1, 1, 32'd40, 5'd5, 32'd4, RW | MR | AL, 1, 32'h0, 0, 0));

    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage, directly downstream of instruction fetch.
- Holds the IF/ID pipeline register (instruction, PC, valid), the 32x32 architectural register file and the RV32I control decoder.
- Also contains the load-use hazard detector. It drives `pc_write_en` back to fetch and presents decoded operands and control to EX.

Parameters:
- `NOP_INSTR`, 32'h00000013, encoding injected on reset/flush (addi x0,x0,0).
- `RESET_PC`, 32'h00000000, value of `pc_q` after reset/flush.

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `instr_in`  input  32  instruction from fetch.
- `pc_in`  input  32  PC of `instr_in`.
- `branch_taken`  input  1  from EX; flushes IF/ID.
- `ex_mem_read`  input  1  instruction in EX is a load.
- `ex_rd`  input  5  destination of instruction in EX.
- `wb_we`  input  1  write-back enable.
- `wb_rd`  input  5  write-back destination.
- `wb_data`  input  32  write-back value.
- `pc_write_en`  output  1  to fetch; 0 stalls the PC.
- `id_valid`  output  1  decoded instruction is real (0 = bubble).
- `id_pc`  output  32  PC of decoded instruction.
- `rs1_data`, `rs2_data`  output  32 each  register operands.
- `rs1`, `rs2`, `rd`  output  5 each  register indices.
- `imm`  output  32  sign-extended immediate.
- `funct3`  output  3  instr[14:12].
- `funct7b5`  output  1  instr[30].
- `reg_write`, `mem_read`, `mem_write`, `alu_src_imm`, `branch`, `jump`, `illegal`  output  1 each  control.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `reset` is asynchronous, active-high.
  - On reset: `instr_q`=`NOP_INSTR`, `pc_q`=`RESET_PC`, `valid_q`=0, all 32 registers = 0.
  - Resulting outputs: `id_valid`=0, all control=0, `pc_write_en`=1.
- IF/ID register update, per rising edge, in priority order:
  - `branch_taken`=1: load `NOP_INSTR`/`RESET_PC`, `valid_q`=0. Flush overrides stall.
  - else `load_use_stall`=1: hold all IF/ID state.
  - else: capture `instr_in`, `pc_in`, `valid_q`=1.
- Load-use hazard detection:
  - `load_use_stall` = `valid_q` & `ex_mem_read` & (`ex_rd`!=0) & ((`uses_rs1` & `ex_rd`==`rs1`) | (`uses_rs2` & `ex_rd`==`rs2`)).
  - `uses_rs1` is set for JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - `uses_rs2` is set for BRANCH, STORE, OP.
  - `pc_write_en` = ~`load_use_stall`. Combinational, same cycle.
  - During a stall, `id_valid` and all control outputs are forced 0, inserting a bubble into EX. Exactly one bubble is inserted per load-use pair.
- Register file:
  - Write at rising edge when `wb_we` & `wb_rd`!=0. Writes to x0 are ignored; x0 always reads 0.
  - Reads are combinational on `rs1` = instr_q[19:15] and `rs2` = instr_q[24:20].
- Decode, by `opcode` = instr_q[6:0]; all outputs are combinational from `instr_q`:
  - LUI (0110111) / AUIPC (0010111): `reg_write`, U-imm.
  - JAL (1101111): `reg_write`, `jump`, J-imm.
  - JALR (1100111): `reg_write`, `jump`, `alu_src_imm`, I-imm.
  - BRANCH (1100011): `branch`, B-imm.
  - LOAD (0000011): `reg_write`, `mem_read`, `alu_src_imm`, I-imm.
  - STORE (0100011): `mem_write`, `alu_src_imm`, S-imm.
  - OP-IMM (0010011): `reg_write`, `alu_src_imm`, I-imm.
  - OP (0110011): `reg_write`, imm=0.
  - Any other opcode: `illegal`=1, all other control 0, imm=0.
  - All control outputs, including `illegal`, are gated by `id_valid`.
- Immediates are fully sign-extended from instr_q[31]. B-imm and J-imm have bit0=0. U-imm is {instr[31:12],12'b0}.
- Simultaneous `branch_taken` and `load_use_stall`: flush wins. `pc_write_en` still follows the stall equation; fetch prioritises branch.

Optional Feature:
- Macro: `ID_REGFILE_BYPASS_EN`.
- Defined: write-through bypass. If `wb_we` & `wb_rd`!=0 & `wb_rd`==`rs1` (or `rs2`), the corresponding `rsN_data` = `wb_data` in the same cycle.
- Undefined: reads return the pre-write array contents. The WB-to-ID hazard then becomes the hazard unit's responsibility; no other behaviour changes.

Test Plan:
- Reset, then release with `instr_in`=32'h00500093 (addi x1,x0,5), `pc_in`=4 -> cycle after release: `id_valid`=1, `rd`=1, `imm`=5, `reg_write`=1, `alu_src_imm`=1, `id_pc`=4.
- `wb_we`=1, `wb_rd`=0, `wb_data`=32'hDEADBEEF; later decode of rs1=x0 -> `rs1_data`=0.
- EX holds load to x5 (`ex_mem_read`=1, `ex_rd`=5); ID holds add x6,x5,x7 -> `pc_write_en`=0 and `id_valid`=0 for one cycle, IF/ID held. Next cycle with `ex_mem_read`=0 -> `id_valid`=1, same instruction.
- `branch_taken`=1 together with a stall condition -> next cycle `id_valid`=0, `instr_q`=32'h00000013, `id_pc`=0.
- Decode 32'hFE000EE3 (beq x0,x0,-4) -> `branch`=1, `imm`=32'hFFFFFFFC. Decode 32'hFFFFFFFF -> `illegal`=1.
- `ID_REGFILE_BYPASS_EN` defined: `wb_we`=1, `wb_rd`=3, `wb_data`=32'h12345678 while ID reads rs2=x3 -> `rs2_data`=32'h12345678 the same cycle. Undefined: old value (0).
